vga_sync_decoder: RTL and testbench

Receive-side decoder for the VGA scan the display controller generates. It consumes h_sync/v_sync and 12-bit RGB, measures line and frame timing, and locks onto a stable raster. Once locked it recovers the pixel column/row and the active-video enable. It sits in the verification/loopback path (on-board self-check, bench monitor) opposite the scan generator.

---
 rtl/vga_sync_decoder_pkg.sv | 31 +++
 rtl/vga_sync_decoder_crc16.sv | 26 ++
 rtl/vga_sync_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared types, constants and the CRC step function for the VGA sync decoder.
package vga_sync_decoder_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // 640x480 raster defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_H_START  = 144;
    localparam int unsigned DEF_V_START  = 35;

    // One clock of CRC-16-CCITT over 12 data bits, MSB first
    function automatic logic [15:0] crc16_step12(input logic [15:0] crc, input logic [11:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int unsigned i = 0; i < 12; i++) begin
            fb = c[15] ^ data[11 - i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_crc16.sv
// 12-bit-per-clock CRC-16-CCITT accumulator with synchronous init and enable.
module vga_rx_crc16
    import vga_sync_decoder_pkg::*;
(
    input  logic        clk_25,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [11:0] data,
    output logic [15:0] crc
);

    // Init restarts the accumulation; an enabled word on the init cycle is folded into the fresh seed
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (init && en) begin
            crc <= crc16_step12(CRC_INIT, data);
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step12(crc, data);
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA raster decoder: measures line/frame timing, locks onto a
// stable raster and recovers col/row/disp_ena aligned with the pixel data.
// Optional per-frame active-pixel CRC: define VGA_SYNC_DECODER_CRC_EN.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned H_START     = DEF_H_START,
    parameter int unsigned V_START     = DEF_V_START,
    parameter logic        H_POL       = 1'b0,
    parameter logic        V_POL       = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CNT_W       = 12
)(
    input  logic             clk_25,
    input  logic             reset,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic [3:0]       red,
    input  logic [3:0]       green,
    input  logic [3:0]       blue,
    output logic             locked,
    output logic             disp_ena,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic [11:0]      rgb_out,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             frame_start,
    output logic             timing_err,
    output logic [15:0]      frame_crc,
    output logic             crc_valid
);

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_START + V_ACTIVE);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             h_r, h_prev, v_r, v_prev;
    logic [11:0]      rgb_r;
    logic [CNT_W-1:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
    logic [CNT_W-1:0] cur_line, v_new, line_ref, prev_h, prev_v;
    logic             v_pend, h_seen, first_pending, frame_bad;
    logic             h_edge, v_edge, fs_evt, h_sat;
    logic             consistent, frame_match, lock_fault, act;
    logic [3:0]       match_cnt, match_inc;
    state_t           state;

    // Register the pins once; sync registers rest at their inactive level
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            h_r    <= ~H_POL;
            h_prev <= ~H_POL;
            v_r    <= ~V_POL;
            v_prev <= ~V_POL;
            rgb_r  <= '0;
        end else begin
            h_r    <= h_sync;
            h_prev <= h_r;
            v_r    <= v_sync;
            v_prev <= v_r;
            rgb_r  <= {red, green, blue};
        end
    end

    // Edge detection, next counter values and lock qualification terms.
    // hcnt_nx/vcnt_nx give the position of the pixel currently held in rgb_r,
    // which is what keeps pin-to-output latency at two clocks.
    always_comb begin
        h_edge     = (h_r == H_POL) && (h_prev != H_POL);
        v_edge     = (v_r == V_POL) && (v_prev != V_POL);
        fs_evt     = h_edge && (v_pend || v_edge);
        h_sat      = (hcnt == '1) && !h_edge;
        cur_line   = hcnt + ONE;
        v_new      = vcnt + ONE;
        hcnt_nx    = h_edge ? '0 : ((hcnt == '1) ? hcnt : cur_line);
        if (!h_edge)
            vcnt_nx = vcnt;
        else if (fs_evt)
            vcnt_nx = '0;
        else
            vcnt_nx = (vcnt == '1) ? vcnt : v_new;
        consistent  = !frame_bad && !first_pending && h_seen && (cur_line == line_ref);
        frame_match = consistent && (cur_line != '0) && (v_new != '0) &&
                      (cur_line == prev_h) && (v_new == prev_v);
        lock_fault  = h_edge && h_seen &&
                      ((cur_line != prev_h) || (fs_evt && (v_new != prev_v)));
        match_inc   = match_cnt + 4'd1;
        act         = locked && (hcnt_nx >= H_LO) && (hcnt_nx < H_HI) &&
                      (vcnt_nx >= V_LO) && (vcnt_nx < V_HI);
    end

    // Line/frame counters, measured totals and per-frame line consistency
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            hcnt          <= '0;
            vcnt          <= '0;
            v_pend        <= 1'b0;
            h_seen        <= 1'b0;
            h_total       <= '0;
            v_total       <= '0;
            frame_start   <= 1'b0;
            line_ref      <= '0;
            first_pending <= 1'b1;
            frame_bad     <= 1'b1;
        end else begin
            hcnt        <= hcnt_nx;
            vcnt        <= vcnt_nx;
            frame_start <= fs_evt;
            if (fs_evt)
                v_pend <= 1'b0;
            else if (v_edge)
                v_pend <= 1'b1;
            if (h_edge) begin
                h_total <= cur_line;
                h_seen  <= 1'b1;
                if (fs_evt) begin
                    v_total       <= v_new;
                    first_pending <= 1'b1;
                    frame_bad     <= 1'b0;
                end else if (first_pending) begin
                    line_ref      <= cur_line;
                    first_pending <= 1'b0;
                    if (!h_seen)
                        frame_bad <= 1'b1;
                end else if (!h_seen || (cur_line != line_ref)) begin
                    frame_bad <= 1'b1;
                end
            end else if (h_sat) begin
                h_seen <= 1'b0;
            end
        end
    end

    // Lock FSM: SEARCH -> MEASURE -> LOCKED, stepped at frame starts
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            prev_h     <= '0;
            prev_v     <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            if (h_sat) begin
                if (state == LOCKED)
                    timing_err <= 1'b1;
                state     <= SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (fs_evt) begin
                            state     <= MEASURE;
                            prev_h    <= '0;
                            prev_v    <= '0;
                            match_cnt <= '0;
                        end
                    end
                    MEASURE: begin
                        if (fs_evt) begin
                            prev_h <= cur_line;
                            prev_v <= v_new;
                            if (frame_match) begin
                                match_cnt <= match_inc;
                                if (match_inc == 4'(LOCK_FRAMES)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (lock_fault) begin
                            timing_err <= 1'b1;
                            locked     <= 1'b0;
                            state      <= MEASURE;
                            match_cnt  <= '0;
                            if (fs_evt) begin
                                prev_h <= cur_line;
                                prev_v <= v_new;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Recovered position and gated pixel data
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            disp_ena <= 1'b0;
            col      <= '0;
            row      <= '0;
            rgb_out  <= '0;
        end else begin
            disp_ena <= act;
            col      <= act ? (hcnt_nx - H_LO) : '0;
            row      <= act ? (vcnt_nx - V_LO) : '0;
            rgb_out  <= act ? rgb_r : '0;
        end
    end

`ifdef VGA_SYNC_DECODER_CRC_EN
    logic [15:0] crc_cur;
    logic        crc_frame_ok;

    vga_rx_crc16 u_crc (
        .clk_25 (clk_25),
        .reset  (reset),
        .init   (frame_start),
        .en     (disp_ena),
        .data   (rgb_out),
        .crc    (crc_cur)
    );

    // Publish the CRC of a frame only if lock held from its start to its end
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            frame_crc    <= '0;
            crc_valid    <= 1'b0;
            crc_frame_ok <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (frame_start) begin
                crc_frame_ok <= locked;
                if (crc_frame_ok && locked) begin
                    frame_crc <= crc_cur;
                    crc_valid <= 1'b1;
                end
            end else if (!locked) begin
                crc_frame_ok <= 1'b0;
            end
        end
    end
`else
    assign frame_crc = '0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 16x8 raster
// (8x4 active, H_START 4, V_START 2) so full lock sequences stay short.
module tb_vga_sync_decoder;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HS = 4;
    localparam int VS = 2;
    localparam int HT = 16;
    localparam int VT = 8;
    localparam int CW = 12;

    logic          clk_25 = 1'b0;
    logic          reset;
    logic          h_sync, v_sync;
    logic [3:0]    red, green, blue;
    logic          locked, disp_ena, frame_start, timing_err, crc_valid;
    logic [CW-1:0] col, row, h_total, v_total;
    logic [11:0]   rgb_out;
    logic [15:0]   frame_crc;

    vga_sync_decoder #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .H_START     (HS),
        .V_START     (VS),
        .H_POL       (1'b0),
        .V_POL       (1'b0),
        .LOCK_FRAMES (2),
        .CNT_W       (CW)
    ) dut (
        .clk_25      (clk_25),
        .reset       (reset),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .locked      (locked),
        .disp_ena    (disp_ena),
        .col         (col),
        .row         (row),
        .rgb_out     (rgb_out),
        .h_total     (h_total),
        .v_total     (v_total),
        .frame_start (frame_start),
        .timing_err  (timing_err),
        .frame_crc   (frame_crc),
        .crc_valid   (crc_valid)
    );

    always #5 clk_25 = ~clk_25;

    typedef struct {int col; int row; logic [11:0] rgb;} pix_t;
    typedef struct {logic lk; int vt; int ht;} fs_t;

    pix_t        pix_q[$];
    fs_t         fs_q[$];
    logic [15:0] crc_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_err = 0;
    logic [15:0] mcrc = 16'hFFFF;
    bit          prev_thru = 1'b0;
    pix_t        mp;
    fs_t         mf;
    logic [15:0] mc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: word xored into the top of the register, then 12 shifts
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c ^ {d, 4'h0};
        repeat (12) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    // One frame of the scan generator; pushes the expected DUT responses
    task automatic send_frame(input bit lk, input int vt_exp, input int ht_exp, input bit const_px,
                              input int stretch, input int v_early, input int rst_line,
                              input int rst_x, input int fidx);
        bit          thru;
        bit          active;
        int          len;
        logic [11:0] px;
        fs_t         f;
        pix_t        p;
        thru = lk;
        for (int y = 0; y < VT; y++) begin
            len = (y == stretch) ? HT + 1 : HT;
            for (int x = 0; x < len; x++) begin
                if (y == 0 && x == 0) begin
                    f.lk = lk; f.vt = vt_exp; f.ht = ht_exp;
                    fs_q.push_back(f);
`ifdef VGA_SYNC_DECODER_CRC_EN
                    if (prev_thru && lk) crc_q.push_back(mcrc);
`endif
                    mcrc = 16'hFFFF;
                end
                if (y == rst_line && x == rst_x) begin
                    reset = 1'b1;
                    #1;
                    check("rst_locked", locked, 0);
                    check("rst_disp_ena", disp_ena, 0);
                    check("rst_col", col, 0);
                    check("rst_row", row, 0);
                    check("rst_rgb", rgb_out, 0);
                    check("rst_h_total", h_total, 0);
                    check("rst_v_total", v_total, 0);
                    check("rst_frame_start", frame_start, 0);
                    check("rst_timing_err", timing_err, 0);
                    check("rst_crc", {frame_crc, crc_valid}, 0);
                    lk = 1'b0;
                    thru = 1'b0;
                end
                h_sync = (x >= 2);
                v_sync = !((y == 0) || (y == VT - 1 && x >= len - v_early));
                active = (x >= HS) && (x < HS + HA) && (y >= VS) && (y < VS + VA);
                if (!active)
                    px = 12'hABC;
                else if (const_px)
                    px = 12'hF00;
                else
                    px = {4'(x - HS), 4'(y - VS), 4'(fidx)};
                if (active && lk) begin
                    p.col = x - HS; p.row = y - VS; p.rgb = px;
                    pix_q.push_back(p);
                    mcrc = ref_crc(mcrc, px);
                end
                {red, green, blue} = px;
                tick();
                if (reset) reset = 1'b0;
            end
        end
        prev_thru = thru && (stretch < 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk_25) begin
        if (!reset) begin
            if (disp_ena) begin
                if (pix_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pix_unexpected: got col %0d row %0d required no disp_ena", col, row);
                end else begin
                    mp = pix_q.pop_front();
                    check("col", col, mp.col);
                    check("row", row, mp.row);
                    check("rgb_out", rgb_out, mp.rgb);
                end
            end else begin
                check("blank_outputs", {col, row, rgb_out}, 0);
            end
            if (frame_start) begin
                if (fs_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fs_unexpected: got frame_start 1 required 0 at %0t", $time);
                end else begin
                    mf = fs_q.pop_front();
                    check("fs_locked", locked, mf.lk);
                    if (mf.vt >= 0) check("v_total", v_total, mf.vt);
                    if (mf.ht >= 0) check("h_total", h_total, mf.ht);
                end
            end
            if (timing_err) n_err++;
`ifdef VGA_SYNC_DECODER_CRC_EN
            if (crc_valid) begin
                if (crc_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL crc_unexpected: got crc_valid 1 required 0 at %0t", $time);
                end else begin
                    mc = crc_q.pop_front();
                    check("frame_crc", frame_crc, mc);
                end
            end
`else
            check("crc_tied_off", {frame_crc, crc_valid}, 0);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1; {red, green, blue} = 12'h000;
        repeat (3) tick();
        check("init_locked", locked, 0);
        check("init_totals", {h_total, v_total}, 0);
        reset = 1'b0;
        repeat (3) tick();
        // initial lock: locked on the 4th frame start
        send_frame(0,  1, -1, 0, -1, 0, -1, -1, 1);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 2);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 3);
        send_frame(1,  8, 16, 0, -1, 0, -1, -1, 4);
        send_frame(1,  8, 16, 1, -1, 0, -1, -1, 5);
        // v edge 10 clocks before the h edge
        send_frame(1,  8, 16, 0, -1, 10, -1, -1, 6);
        // stretched line 6 -> timing_err, relock after two good frames
        send_frame(1,  8, 16, 0, 6, 0, -1, -1, 7);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 8);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 9);
        send_frame(1,  8, 16, 0, -1, 0, -1, -1, 10);
        send_frame(1,  8, 16, 1, -1, 0, -1, -1, 11);
        // reset mid-line, then a full relock sequence
        send_frame(1,  8, 16, 0, -1, 0, 1, 8, 12);
        send_frame(0,  7, 16, 0, -1, 0, -1, -1, 13);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 14);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 15);
        send_frame(1,  8, 16, 0, -1, 0, -1, -1, 0);
        send_frame(1,  8, 16, 0, -1, 0, -1, -1, 1);
        // static h_sync: hcnt saturates, lock lost, no frame_start
        h_sync = 1'b1; v_sync = 1'b1; {red, green, blue} = 12'hABC;
        repeat (4200) tick();
        check("sat_locked", locked, 0);
        prev_thru = 1'b0;
        send_frame(0,  8, -1, 0, -1, 0, -1, -1, 2);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 3);
        send_frame(0,  8, 16, 0, -1, 0, -1, -1, 4);
        send_frame(1,  8, 16, 1, -1, 0, -1, -1, 5);
        send_frame(1,  8, 16, 0, -1, 0, -1, -1, 6);
        h_sync = 1'b1; v_sync = 1'b1;
        repeat (8) tick();
        check("end_locked", locked, 1);
        check("timing_err_count", n_err, 2);
        check("pix_left", pix_q.size(), 0);
        check("fs_left", fs_q.size(), 0);
        check("crc_left", crc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
